rr_dff_bank_arbiter: RTL and testbench

- Round-robin arbiter that shares a single WIDTH-bit synchronous D flip-flop register between NUM_REQ requesters.
- Each requester raises a request with write data. The block grants one requester at a time, captures its data into the shared register, acknowledges it, and waits for release before re-arbitrating.
- Sits in front of the team's synchronous DFF storage and owns all writes to it.
- Drives registered true and complement outputs.

---
 rtl/rr_dff_bank_arbiter.sv | 130 +++++++++++++
 tb/tb_rr_dff_bank_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/rr_dff_bank_arbiter.sv
// ============================================================================
//  Module      : rr_dff_bank_arbiter
//  Description : Round-robin arbiter owning all writes to a shared WIDTH-bit
//                DFF register, with registered true/complement outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_dff_bank_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [NUM_REQ*WIDTH-1:0]   i_data,
    output logic [NUM_REQ-1:0]         o_gnt,
    output logic [NUM_REQ-1:0]         o_ack,
    output logic [WIDTH-1:0]           o_q,
    output logic [WIDTH-1:0]           o_qb,
    output logic                       o_busy
);

    localparam int PW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WRITE   = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t               state_q;
    logic [PW-1:0]        ptr_q;
    logic [PW-1:0]        sel_q;
    logic [NUM_REQ-1:0]   gnt_q;
    logic [NUM_REQ-1:0]   ack_q;
    logic [WIDTH-1:0]     q_q;
    logic [WIDTH-1:0]     qb_q;
    logic                 busy_q;

    logic [PW-1:0]        sel_d;
    logic [PW-1:0]        ptr_d;
    logic [WIDTH-1:0]     wdata_d;

    // First requester at or after ptr, wrapping modulo NUM_REQ.
    function automatic logic [PW-1:0] f_pick(input logic [NUM_REQ-1:0] req,
                                             input logic [PW-1:0]      ptr);
        logic [PW-1:0] sel;
        logic [PW-1:0] idx_v;
        logic          found;
        int            idx;
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx   = (int'(ptr) + i) % NUM_REQ;
            idx_v = PW'(idx);
            if (!found && req[idx_v]) begin
                sel   = idx_v;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    always_comb begin
        sel_d   = f_pick(i_req, ptr_q);
        ptr_d   = (sel_q == PW'(NUM_REQ - 1)) ? '0 : sel_q + 1'b1;
        wdata_d = i_data[sel_q*WIDTH +: WIDTH];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            q_q     <= '0;
            qb_q    <= '1;
            busy_q  <= 1'b0;
        end else begin
            ack_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (|i_req) begin
                        sel_q   <= sel_d;
                        gnt_q   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << sel_d;
                        busy_q  <= 1'b1;
                        state_q <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    // Data is taken here, not at grant time.
                    if (i_req[sel_q]) begin
                        q_q     <= wdata_d;
                        qb_q    <= ~wdata_d;
                        ack_q   <= gnt_q;
                        state_q <= S_RELEASE;
                    end else begin
                        gnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_RELEASE: begin
                    if (!i_req[sel_q]) begin
                        gnt_q   <= '0;
                        ptr_q   <= ptr_d;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_gnt  = gnt_q;
    assign o_ack  = ack_q;
    assign o_q    = q_q;
    assign o_qb   = qb_q;
    assign o_busy = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_rr_dff_bank_arbiter.sv
// ============================================================================
//  Module      : tb_rr_dff_bank_arbiter
//  Description : Scoreboard bench for rr_dff_bank_arbiter with a
//                transaction-level round-robin reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_dff_bank_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic            clk;
    logic            reset;
    logic [N-1:0]    i_req;
    logic [N*W-1:0]  i_data;
    logic [N-1:0]    o_gnt;
    logic [N-1:0]    o_ack;
    logic [W-1:0]    o_q;
    logic [W-1:0]    o_qb;
    logic            o_busy;

    rr_dff_bank_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .i_req  (i_req),
        .i_data (i_data),
        .o_gnt  (o_gnt),
        .o_ack  (o_ack),
        .o_q    (o_q),
        .o_qb   (o_qb),
        .o_busy (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        logic [7:0] d;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         ptr_m    = 0;
    logic [7:0] exp_q    = 8'h00;
    bit         done     = 1'b0;

    task automatic check(input bit ok, input string name,
                         input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    endtask

    // Round-robin rule: first set bit scanning p, p+1, ... modulo N.
    function automatic int pick(input logic [3:0] m, input int p);
        int k;
        for (int i = 0; i < N; i++) begin
            k = (p + i) % N;
            if (m[k[1:0]]) return k;
        end
        return -1;
    endfunction

    // Monitor: samples shortly after each rising edge, inputs only move on falling edges.
    initial begin
        exp_t it;
        forever begin
            @(posedge clk);
            #2;
            if (done) break;
            if (!reset) begin
                exp_q = 8'h00;
                check(o_q == 8'h00,   "rst_q",    o_q,    8'h00);
                check(o_qb == 8'hFF,  "rst_qb",   o_qb,   8'hFF);
                check(o_gnt == 4'b0,  "rst_gnt",  o_gnt,  0);
                check(o_ack == 4'b0,  "rst_ack",  o_ack,  0);
                check(o_busy == 1'b0, "rst_busy", o_busy, 0);
            end else begin
                if (o_ack != 4'b0) begin
                    if (sb.size() == 0) begin
                        check(1'b0, "unexpected_ack", o_ack, 0);
                    end else begin
                        it = sb.pop_front();
                        exp_q = it.d;
                        check(o_ack == (4'b1 << it.idx), "ack_onehot", o_ack, 4'b1 << it.idx);
                        check(o_q == it.d, "write_data", o_q, it.d);
                    end
                end
                check(o_q == exp_q, "q_hold", o_q, exp_q);
                check(o_qb == ~o_q, "qb_compl", o_qb, ~o_q);
                check((o_gnt & (o_gnt - 4'b1)) == 4'b0, "gnt_onehot0", o_gnt, 0);
                check((o_ack & ~o_gnt) == 4'b0, "ack_in_gnt", o_ack, o_gnt);
            end
        end
    end

    // mode: 0 complete, 1 abort before the write edge, 2 reset while in release
    task automatic txn(input logic [3:0] mask, input int mode, input int hold,
                       input logic [7:0] wd);
        int         e;
        logic [3:0] eg;
        for (int k = 0; k < N; k++) i_data[k*W +: W] = 8'($urandom);
        i_req = mask;
        e  = pick(mask, ptr_m);
        eg = 4'b1 << e;
        @(negedge clk);
        check(o_gnt == eg,    "grant",      o_gnt,  eg);
        check(o_busy == 1'b1, "busy_grant", o_busy, 1);
        if (mode == 1) begin
            i_req[e] = 1'b0;
            @(negedge clk);
            check(o_gnt == 4'b0,  "abort_gnt",  o_gnt,  0);
            check(o_busy == 1'b0, "abort_busy", o_busy, 0);
        end else begin
            // Late data change on the granted lane must be what gets written.
            for (int k = 0; k < N; k++) i_data[k*W +: W] = 8'($urandom);
            i_data[e*W +: W] = wd;
            sb.push_back('{e, wd});
            @(negedge clk);
            if (mode == 2) begin
                reset = 1'b0;
                @(negedge clk);
                check(o_gnt == 4'b0,  "midrst_gnt",  o_gnt,  0);
                check(o_busy == 1'b0, "midrst_busy", o_busy, 0);
                reset = 1'b1;
                ptr_m = 0;
            end else begin
                for (int h = 0; h < hold; h++) begin
                    check(o_gnt == eg, "gnt_hold", o_gnt, eg);
                    @(negedge clk);
                end
                i_req[e] = 1'b0;
                @(negedge clk);
                check(o_gnt == 4'b0,  "release_gnt",  o_gnt,  0);
                check(o_busy == 1'b0, "release_busy", o_busy, 0);
                ptr_m = (e + 1) % N;
            end
        end
        i_req = '0;
    endtask

    initial begin
        int r;
        reset  = 1'b0;
        i_req  = 4'b1111;
        i_data = 32'hDEADBEEF;
        repeat (2) @(negedge clk);
        check(o_gnt == 4'b0, "rst_no_grant", o_gnt, 0);
        reset = 1'b1;
        i_req = '0;
        @(negedge clk);
        check(o_busy == 1'b0, "idle_after_rst", o_busy, 0);

        txn(4'b0100, 0, 0, 8'hA5);

        // Fairness with everyone requesting; ptr is 3 after the single write.
        txn(4'b1111, 0, 1, 8'h44);
        txn(4'b1111, 0, 1, 8'h11);
        txn(4'b1111, 0, 1, 8'h22);
        txn(4'b1111, 0, 1, 8'h33);
        txn(4'b1111, 0, 1, 8'h44);
        txn(4'b1111, 0, 1, 8'h11);

        // After serving 0, ptr=1: push it round to 0 via 1..3, then wrap test.
        txn(4'b0010, 0, 0, 8'h5C);
        txn(4'b0100, 0, 0, 8'h6D);
        txn(4'b1000, 0, 2, 8'h7E);
        txn(4'b1010, 0, 0, 8'h81);
        txn(4'b1010, 0, 0, 8'h93);

        txn(4'b0010, 1, 0, 8'h00);
        txn(4'b0010, 1, 0, 8'h00);
        txn(4'b0010, 0, 0, 8'hC3);

        txn(4'b0010, 2, 0, 8'hE7);
        txn(4'b1111, 0, 0, 8'h3C);

        for (int t = 0; t < 60; t++) begin
            r = $urandom_range(0, 9);
            txn(4'($urandom_range(1, 15)),
                (r < 2) ? 1 : ((r == 2) ? 2 : 0),
                $urandom_range(0, 3),
                8'($urandom));
        end

        repeat (3) @(negedge clk);
        check(sb.size() == 0, "sb_empty", sb.size(), 0);
        done = 1'b1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
